// File: rtl/vedic3_dot_acc.sv
// Dot-product accumulator behind the 3-bit Vedic multiplier: sums LEN products with
// saturation and presents each result over a valid/ready handshake.
module vedic3_dot_acc #(
  parameter int LEN   = 4,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             prod_valid,
  output logic             prod_ready,
  input  logic [5:0]       prod_in,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [ACC_W-1:0] sum_out,
  output logic             sum_sat
);

  localparam int CNT_W = (LEN > 2) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = '1;

  typedef enum logic {ACCUM, HOLD} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic [ACC_W-1:0]   sum_out_q, sum_out_d;
  logic               sum_sat_q, sum_sat_d;
  logic [ACC_W:0]     add_res;

  // Returns {saturated, value}; the value clamps to all-ones on carry out.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [5:0]       p);
    logic [ACC_W:0] s;
    s = {1'b0, a} + (ACC_W + 1)'(p);
    if (s[ACC_W]) begin
      return {1'b1, ACC_MAX};
    end
    return s;
  endfunction

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sat_d      = sat_q;
    sum_out_d  = sum_out_q;
    sum_sat_d  = sum_sat_q;
    add_res    = sat_add(acc_q, prod_in);
    prod_ready = (state_q == ACCUM);
    sum_valid  = (state_q == HOLD);

    if (clr) begin
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (prod_valid) begin
            if (cnt_q == CNT_LAST) begin
              state_d   = HOLD;
              sum_out_d = add_res[ACC_W-1:0];
              sum_sat_d = sat_q | add_res[ACC_W];
              acc_d     = '0;
              cnt_d     = '0;
              sat_d     = 1'b0;
            end else begin
              acc_d = add_res[ACC_W-1:0];
              cnt_d = cnt_q + CNT_W'(1);
              sat_d = sat_q | add_res[ACC_W];
            end
          end
        end
        HOLD: begin
          if (sum_ready) begin
            state_d = ACCUM;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      sum_out_q <= '0;
      sum_sat_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      sum_out_q <= sum_out_d;
      sum_sat_q <= sum_sat_d;
    end
  end

  assign sum_out = sum_out_q;
  assign sum_sat = sum_sat_q;

endmodule
